// File: rtl/gpio_in_conditioner_if.sv
// Pin, configuration and status bundle for gpio_in_conditioner.
// master drives pins/config, slave is the conditioner itself.
interface gpio_in_conditioner_if #(
  parameter int NumInputs = 16,
  parameter int CntWidth  = 16
);
  logic [NumInputs-1:0] pins_i;
  logic [CntWidth-1:0]  debounce_cycles_i;
  logic [NumInputs-1:0] debounce_en_i;
  logic [NumInputs-1:0] rise_ie_i;
  logic [NumInputs-1:0] fall_ie_i;
  logic [NumInputs-1:0] intr_clear_i;
  logic [NumInputs-1:0] state_o;
  logic [NumInputs-1:0] rise_o;
  logic [NumInputs-1:0] fall_o;
  logic [NumInputs-1:0] intr_status_o;
  logic                 irq_o;

  modport master (
    output pins_i,
    output debounce_cycles_i,
    output debounce_en_i,
    output rise_ie_i,
    output fall_ie_i,
    output intr_clear_i,
    input  state_o,
    input  rise_o,
    input  fall_o,
    input  intr_status_o,
    input  irq_o
  );

  modport slave (
    input  pins_i,
    input  debounce_cycles_i,
    input  debounce_en_i,
    input  rise_ie_i,
    input  fall_ie_i,
    input  intr_clear_i,
    output state_o,
    output rise_o,
    output fall_o,
    output intr_status_o,
    output irq_o
  );
endinterface

// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioner: polarity fix, sync, debounce,
// edge detect and sticky W1C interrupt status per channel.
module gpio_in_conditioner #(
  parameter int NumInputs  = 16,
  parameter int CntWidth   = 16,
  parameter int SyncStages = 2,
  parameter logic [NumInputs-1:0] ActiveLowMask = '1
) (
  input logic clk_sys_i,
  input logic rst_sys_ni,
  gpio_in_conditioner_if.slave io
);

  localparam int N = NumInputs;

  logic [N-1:0] sync_q [SyncStages];
  logic [N-1:0] logic_in;
  logic [N-1:0] sync;
  logic [N-1:0] state_q;
  logic [N-1:0] state_d;
  logic [N-1:0] rise_q;
  logic [N-1:0] fall_q;
  logic [N-1:0] status_q;
  logic [N-1:0] status_d;

  assign logic_in = io.pins_i ^ ActiveLowMask;
  assign sync     = sync_q[SyncStages-1];

  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      for (int s = 0; s < SyncStages; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= logic_in;
      for (int s = 1; s < SyncStages; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] cnt_nxt;
    logic [CntWidth:0]   thr;
    logic [CntWidth:0]   cnt_inc;
    logic                state_nxt;

    // Extra bit keeps cnt+1 from wrapping at the top of range.
    assign thr = (io.debounce_en_i[i] &&
                  io.debounce_cycles_i != '0)
               ? {1'b0, io.debounce_cycles_i}
               : (CntWidth+1)'(1);
    assign cnt_inc = {1'b0, cnt_q} + (CntWidth+1)'(1);

    always_comb begin
      state_nxt = state_q[i];
      cnt_nxt   = cnt_q;
      if (sync[i] == state_q[i]) begin
        cnt_nxt = '0;
      end else if (cnt_inc >= thr) begin
        state_nxt = sync[i];
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt_inc[CntWidth-1:0];
      end
    end

    always_ff @(posedge clk_sys_i) begin
      if (!rst_sys_ni) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_nxt;
      end
    end

    assign state_d[i] = state_nxt;
  end

  // Set wins over a simultaneous clear.
  assign status_d = (rise_q & io.rise_ie_i)
                  | (fall_q & io.fall_ie_i)
                  | (status_q & ~io.intr_clear_i);

  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      state_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      rise_q   <= state_d & ~state_q;
      fall_q   <= ~state_d & state_q;
      status_q <= status_d;
    end
  end

  assign io.state_o       = state_q;
  assign io.rise_o        = rise_q;
  assign io.fall_o        = fall_q;
  assign io.intr_status_o = status_q;
  assign io.irq_o         = |status_q;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Self-checking bench for gpio_in_conditioner: vector table
// with latency scoreboard plus hand-written corner sequences.
module tb_gpio_in_conditioner;

  localparam int N = 16;
  localparam int W = 16;
  localparam int S = 2;
  localparam logic [N-1:0] MASK = 16'h00FF;

  typedef struct {
    string name;
    int    ch;
    bit    en;
    int    thr;
    int    pulse;
    int    lat;
  } vec_t;

  typedef struct {
    int lat;
    int edges;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];
  vec_t vecs [11];

  always #5 clk = ~clk;

  gpio_in_conditioner_if #(.NumInputs(N), .CntWidth(W)) bus ();

  gpio_in_conditioner #(
    .NumInputs(N),
    .CntWidth(W),
    .SyncStages(S),
    .ActiveLowMask(MASK)
  ) dut (
    .clk_sys_i(clk),
    .rst_sys_ni(rst_n),
    .io(bus.slave)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_pin(input int ch, input bit active);
    bus.pins_i[ch] = active ? ~MASK[ch] : MASK[ch];
  endtask

  always @(negedge clk) begin
    check("rise_fall_excl", 32'(bus.rise_o & bus.fall_o), 32'd0);
  end

  task automatic run_vec(input vec_t v);
    int first;
    int rises;
    int falls;
    exp_t e;
    bus.debounce_cycles_i = W'(v.thr);
    bus.debounce_en_i = '0;
    bus.debounce_en_i[v.ch] = v.en;
    repeat (3) @(negedge clk);
    sb.push_back('{lat: v.lat, edges: (v.lat != 0) ? 1 : 0});
    set_pin(v.ch, 1'b1);
    first = 0;
    rises = 0;
    falls = 0;
    for (int k = 1; k <= 2 * v.thr + 30; k++) begin
      @(negedge clk);
      if (v.pulse != 0 && k == v.pulse) set_pin(v.ch, 1'b0);
      if (bus.rise_o[v.ch]) rises++;
      if (bus.fall_o[v.ch]) falls++;
      if (first == 0 && bus.state_o[v.ch]) begin
        first = k;
        check({v.name, " rise_with_state"},
              32'(bus.rise_o[v.ch]), 32'd1);
      end
    end
    set_pin(v.ch, 1'b0);
    for (int k = 0; k < v.thr + 10; k++) begin
      @(negedge clk);
      if (bus.fall_o[v.ch]) falls++;
    end
    e = sb.pop_front();
    check({v.name, " latency"}, 32'(first), 32'(e.lat));
    check({v.name, " rises"}, 32'(rises), 32'(e.edges));
    check({v.name, " falls"}, 32'(falls), 32'(e.edges));
    check({v.name, " idle"}, 32'(bus.state_o[v.ch]), 32'd0);
  endtask

  task automatic wait_rise(input string name, input int ch);
    int n = 0;
    while (!bus.rise_o[ch] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, " rise_seen"}, 32'(bus.rise_o[ch]), 32'd1);
  endtask

  task automatic wait_fall(input string name, input int ch);
    int n = 0;
    while (!bus.fall_o[ch] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, " fall_seen"}, 32'(bus.fall_o[ch]), 32'd1);
  endtask

  initial begin
    vecs[0]  = '{"bypass",      0,  1'b0, 0,  0,  3};
    vecs[1]  = '{"glitch4",     3,  1'b1, 5,  4,  0};
    vecs[2]  = '{"pulse5",      3,  1'b1, 5,  5,  7};
    vecs[3]  = '{"stable5",     3,  1'b1, 5,  0,  7};
    vecs[4]  = '{"dis_thr7",    9,  1'b0, 7,  0,  3};
    vecs[5]  = '{"thr0",        9,  1'b1, 0,  0,  3};
    vecs[6]  = '{"thr1",        12, 1'b1, 1,  0,  3};
    vecs[7]  = '{"thr2",        12, 1'b1, 2,  0,  4};
    vecs[8]  = '{"glitch19",    5,  1'b1, 20, 19, 0};
    vecs[9]  = '{"stable20",    5,  1'b1, 20, 0,  22};
    vecs[10] = '{"thr3_ch15",   15, 1'b1, 3,  0,  5};

    bus.pins_i            = MASK;
    bus.debounce_cycles_i = '0;
    bus.debounce_en_i     = '0;
    bus.rise_ie_i         = '0;
    bus.fall_ie_i         = '0;
    bus.intr_clear_i      = '0;

    repeat (3) @(negedge clk);
    check("rst state", 32'(bus.state_o), 32'd0);
    check("rst rise", 32'(bus.rise_o), 32'd0);
    check("rst fall", 32'(bus.fall_o), 32'd0);
    check("rst status", 32'(bus.intr_status_o), 32'd0);
    check("rst irq", 32'(bus.irq_o), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst state", 32'(bus.state_o), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Interrupt on enabled rise only, then W1C.
    bus.debounce_en_i = '0;
    bus.rise_ie_i = 16'h0002;
    set_pin(1, 1'b1);
    @(negedge clk);
    wait_rise("irq", 1);
    check("irq status_lag", 32'(bus.intr_status_o), 32'd0);
    @(negedge clk);
    check("irq status_set", 32'(bus.intr_status_o), 32'h2);
    check("irq irq_set", 32'(bus.irq_o), 32'd1);
    set_pin(1, 1'b0);
    wait_fall("irq", 1);
    @(negedge clk);
    check("irq fall_no_eff", 32'(bus.intr_status_o), 32'h2);
    bus.intr_clear_i[1] = 1'b1;
    @(negedge clk);
    bus.intr_clear_i = '0;
    check("irq cleared", 32'(bus.intr_status_o), 32'd0);
    check("irq irq_clr", 32'(bus.irq_o), 32'd0);

    // Clear arriving in the same cycle as an enabled fall.
    bus.rise_ie_i = '0;
    bus.fall_ie_i = 16'h0004;
    set_pin(2, 1'b1);
    @(negedge clk);
    wait_rise("coll", 2);
    @(negedge clk);
    check("coll no_rise_set", 32'(bus.intr_status_o), 32'd0);
    set_pin(2, 1'b0);
    wait_fall("coll", 2);
    bus.intr_clear_i[2] = 1'b1;
    @(negedge clk);
    bus.intr_clear_i = '0;
    check("coll set_wins", 32'(bus.intr_status_o), 32'h4);
    check("coll irq", 32'(bus.irq_o), 32'd1);

    // Enable dropped mid-count.
    bus.debounce_cycles_i = W'(100);
    bus.debounce_en_i = 16'h0010;
    set_pin(4, 1'b1);
    repeat (52) @(negedge clk);
    check("endrop before", 32'(bus.state_o[4]), 32'd0);
    bus.debounce_en_i = '0;
    @(negedge clk);
    check("endrop state", 32'(bus.state_o[4]), 32'd1);
    check("endrop rise", 32'(bus.rise_o[4]), 32'd1);
    set_pin(4, 1'b0);
    repeat (6) @(negedge clk);
    check("endrop idle", 32'(bus.state_o[4]), 32'd0);

    // Threshold lowered below the running count.
    bus.debounce_en_i = 16'h0040;
    set_pin(6, 1'b1);
    repeat (52) @(negedge clk);
    check("thrlow before", 32'(bus.state_o[6]), 32'd0);
    bus.debounce_cycles_i = W'(10);
    @(negedge clk);
    check("thrlow state", 32'(bus.state_o[6]), 32'd1);
    set_pin(6, 1'b0);
    repeat (15) @(negedge clk);
    check("thrlow idle", 32'(bus.state_o[6]), 32'd0);

    // Reset mid-count with status bit 2 still set.
    bus.debounce_cycles_i = W'(100);
    bus.debounce_en_i = 16'h0010;
    set_pin(4, 1'b1);
    repeat (52) @(negedge clk);
    check("mrst pre_status", 32'(bus.intr_status_o), 32'h4);
    rst_n = 1'b0;
    bus.debounce_en_i = '0;
    @(negedge clk);
    check("mrst state", 32'(bus.state_o), 32'd0);
    check("mrst status", 32'(bus.intr_status_o), 32'd0);
    check("mrst irq", 32'(bus.irq_o), 32'd0);
    check("mrst rise", 32'(bus.rise_o), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("mrst edge2", 32'(bus.state_o[4]), 32'd0);
    @(negedge clk);
    check("mrst edge3", 32'(bus.state_o), 32'h10);
    check("mrst rise3", 32'(bus.rise_o[4]), 32'd1);
    @(negedge clk);
    check("mrst rise_1cyc", 32'(bus.rise_o[4]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_in_conditioner.md
Name: gpio_in_conditioner

Overview:
- Parametrised input-conditioning block for switch/joystick/detect-style GPIO inputs. Replaces plain inversion at the top level.
- Per channel: polarity correction, multi-stage synchroniser, programmable debounce, rise/fall edge detection and a sticky interrupt status with write-1-to-clear.
- Sits between the input pins and the GPIO input/interrupt logic in clk_sys domain; output state_o drives gp_i.

Parameters:
- NumInputs, 16, number of conditioned channels (1..32).
- CntWidth, 16, width of debounce counter and threshold.
- SyncStages, 2, synchroniser flop stages (>=2).
- ActiveLowMask, '1 (NumInputs bits), bit i set = pin i is active-low and is inverted before sync.

Ports:
- clk_sys_i  in  1  system clock.
- rst_sys_ni  in  1  synchronous active-low reset.
- pins_i  in  NumInputs  raw asynchronous pin levels.
- debounce_cycles_i  in  CntWidth  stable-cycle threshold, shared by all channels; quasi-static.
- debounce_en_i  in  NumInputs  per-channel debounce enable.
- rise_ie_i  in  NumInputs  per-channel rising-edge interrupt enable.
- fall_ie_i  in  NumInputs  per-channel falling-edge interrupt enable.
- intr_clear_i  in  NumInputs  one-cycle W1C pulse per channel.
- state_o  out  NumInputs  debounced logical level (1 = active).
- rise_o  out  NumInputs  one-cycle pulse on 0->1 of state_o.
- fall_o  out  NumInputs  one-cycle pulse on 1->0 of state_o.
- intr_status_o  out  NumInputs  sticky edge status.
- irq_o  out  1  OR of intr_status_o.

Behaviour:
- Clock and reset: one clock, clk_sys_i. Reset is synchronous and active-low on rst_sys_ni. All flops update on the rising edge of clk_sys_i.
- Reset values: every synchroniser stage, state_o, rise_o, fall_o, intr_status_o, irq_o and all counters are 0.
- Polarity: logic_in[i] = pins_i[i] ^ ActiveLowMask[i]. It feeds a SyncStages-deep flop chain; the output of the chain is sync[i].
- Effective threshold: thr = (debounce_en_i[i] && debounce_cycles_i != 0) ? debounce_cycles_i : 1.
- Debounce counter, per channel:
  - If sync == state_o, cnt <= 0.
  - Else if cnt + 1 >= thr, state_o <= sync and cnt <= 0.
  - Else cnt <= cnt + 1.
  - The comparison is done at CntWidth+1 bits, so the increment never wraps.
  - A glitch shorter than thr cycles does not change state_o. Any cycle with sync == state_o restarts the count.
- Latency from a stable pin change to state_o:
  - Debounce disabled: SyncStages+1 clock edges.
  - Debounce enabled with threshold N: SyncStages+N edges.
- Mid-count changes:
  - If debounce_en_i falls, thr becomes 1 and state_o follows on the next edge.
  - If debounce_cycles_i is lowered below the current cnt, the >= compare fires on the next edge.
- Edges:
  - rise_o[i] and fall_o[i] are registered. They are high for exactly the one cycle in which state_o[i] shows its new value.
  - They are never both high.
- Interrupt status, per channel:
  - set = (rise_o & rise_ie_i) | (fall_o & fall_ie_i).
  - next = set | (intr_status_o & ~intr_clear_i).
  - If set and clear occur in the same cycle, set wins.
  - Clearing a bit that is already 0 has no effect.
  - Changing an enable does not alter bits that are already set.
- irq_o: combinational OR of intr_status_o, so it is 0 in reset.
- Reset asserted mid-count: counter, state and status return to 0 on the next edge. After release, an input held active reaches state_o with the normal latency and produces a rise_o pulse.

Test Plan:
- Reset and bypass:
  - Stimulus: ActiveLowMask bit0=1, pins_i[0]=1 during reset, release, then drive pins_i[0]=0; SyncStages=2, debounce_en_i=0.
  - Response: state_o[0]=0 during and after reset; state_o[0]=1 exactly 3 edges after the pin change; rise_o[0] high for 1 cycle.
- Glitch rejection:
  - Stimulus: debounce_cycles_i=5, debounce_en_i[3]=1; 4-cycle active pulse on channel 3, then a stable level.
  - Response: the 4-cycle pulse gives no state_o[3] change and no rise_o; the stable level gives state_o[3]=1 at 2+5=7 edges after the change.
- Threshold zero:
  - Stimulus: debounce_cycles_i=0, debounce_en_i=all ones.
  - Response: behaves as bypass, with latency 3 edges.
- Interrupts:
  - Stimulus: rise_ie_i[1]=1, fall_ie_i[1]=0; toggle channel 1 high then low; pulse intr_clear_i[1].
  - Response: intr_status_o[1] and irq_o set on the rise; the fall causes no extra effect; the clear pulse gives irq_o=0 on the next edge.
- Set/clear collision:
  - Stimulus: intr_clear_i[2] pulsed in the same cycle as an enabled fall_o[2].
  - Response: intr_status_o[2] remains 1.
- Mid-operation reset and enable drop:
  - Stimulus: debounce_cycles_i=100 with cnt at 50; first drop debounce_en_i, then in a separate run assert reset at cnt=50.
  - Response: with the enable dropped, state_o updates on the next edge. With reset, all outputs are 0 next edge; an active input held through release reappears 3 edges after release with a rise_o pulse.
